// File: rtl/cpu6_pipereg_ifid_hs_pkg.sv
// Shared constants for the cpu6 IF->ID pipeline register: default widths,
// the bubble instruction and the packed payload bundle width.
package cpu6_pipereg_ifid_hs_pkg;

    localparam int          CPU6_XLEN      = 32;
    localparam int          CPU6_ILEN      = 32;
    localparam int          CPU6_CNT_W     = 16;
    localparam logic [31:0] CPU6_NOP_INSTR = 32'h0000_0013;

    // Payload bundle is {pc, instr, fault}.
    localparam int CPU6_BUNDLE_W = CPU6_XLEN + CPU6_ILEN + 1;

    function automatic int bundle_w(input int xlen, input int ilen);
        return xlen + ilen + 1;
    endfunction

endpackage

// File: rtl/cpu6_pipereg_ifid_hs_entry.sv
// One pipeline-register entry: a valid flop with async and sync clear, and a
// load-enabled payload register that holds its value when not loaded.
module cpu6_pipereg_entry
    import cpu6_pipereg_ifid_hs_pkg::*;
#(
    parameter int W = CPU6_BUNDLE_W
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         valid_nxt,
    input  logic         sync_clr,
    input  logic         load,
    input  logic [W-1:0] din,
    output logic         valid,
    output logic [W-1:0] dout
);

    logic         valid_d, valid_q;
    logic [W-1:0] data_d, data_q;

    // A beat loaded in a flush cycle is discarded, so the payload keeps its old value.
    always_comb begin
        valid_d = sync_clr ? 1'b0 : valid_nxt;
        data_d  = (load && !sync_clr) ? din : data_q;
    end

    // NOTE: the payload is reset as well, so pcD reads zero straight out of reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign dout  = data_q;

endmodule

// File: rtl/cpu6_pipereg_ifid_hs.sv
// cpu6 IF->ID pipeline register with valid/ready handshake, flush, NOP bubbles,
// fault sideband and stall counter. CPU6_IFID_SKID_EN adds a registered-ready skid entry.
module cpu6_pipereg_ifid_hs
    import cpu6_pipereg_ifid_hs_pkg::*;
#(
    parameter int              XLEN      = CPU6_XLEN,
    parameter int              ILEN      = CPU6_ILEN,
    parameter logic [ILEN-1:0] NOP_INSTR = CPU6_NOP_INSTR,
    parameter int              CNT_W     = CPU6_CNT_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  pc,
    input  logic [ILEN-1:0]  instr,
    input  logic             fault,
    input  logic             flush,
    output logic             outD_valid,
    input  logic             outD_ready,
    output logic [XLEN-1:0]  pcD,
    output logic [ILEN-1:0]  instrD,
    output logic             faultD,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int BW = bundle_w(XLEN, ILEN);

    logic          accept, consume;
    logic          valid_m, valid_m_nxt, load_m;
    logic [BW-1:0] in_bundle, m_din, m_bundle;

    assign in_bundle = {pc, instr, fault};
    assign accept    = in_valid & in_ready;
    assign consume   = valid_m & outD_ready;

`ifdef CPU6_IFID_SKID_EN
    logic          valid_s, valid_s_nxt, load_s;
    logic [BW-1:0] s_bundle;

    // Occupancy EMPTY/ONE/TWO is encoded by {valid_s, valid_m}; S is always the younger beat.
    always_comb begin
        in_ready    = ~valid_s;
        load_s      = accept & valid_m & ~consume;
        valid_s_nxt = load_s | (valid_s & ~consume);
        load_m      = (accept & ~valid_m) | (consume & (valid_s | accept));
        valid_m_nxt = valid_s | accept | (valid_m & ~consume);
        m_din       = valid_s ? s_bundle : in_bundle;
    end

    cpu6_pipereg_entry #(.W(BW)) u_entry_s (
        .clk       (clk),
        .resetn    (resetn),
        .valid_nxt (valid_s_nxt),
        .sync_clr  (flush),
        .load      (load_s),
        .din       (in_bundle),
        .valid     (valid_s),
        .dout      (s_bundle)
    );
`else
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        in_ready    = ~valid_m | outD_ready;
        load_m      = accept;
        valid_m_nxt = accept | (valid_m & ~consume);
        m_din       = in_bundle;
    end
`endif

    cpu6_pipereg_entry #(.W(BW)) u_entry_m (
        .clk       (clk),
        .resetn    (resetn),
        .valid_nxt (valid_m_nxt),
        .sync_clr  (flush),
        .load      (load_m),
        .din       (m_din),
        .valid     (valid_m),
        .dout      (m_bundle)
    );

    assign outD_valid = valid_m;
    assign pcD        = m_bundle[BW-1 -: XLEN];
    assign instrD     = valid_m ? m_bundle[ILEN:1] : NOP_INSTR;
    assign faultD     = valid_m & m_bundle[0];

    // Saturating stall counter; flush does not clear it.
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (valid_m && !outD_ready && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;

endmodule
